ssp_tx_serializer: RTL and testbench

//  Read side of the SSP transmit path. Pops bytes from the 4-deep TX fifo_4
//  (write side is driven by the host bus) and shifts them out serially.

---
 rtl/ssp_tx_serializer_if.sv | 36 +++
 rtl/ssp_tx_serializer.sv | 136 +++++++++++++
 tb/tb_ssp_tx_serializer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ssp_tx_serializer_if.sv
// Signal bundle between the TX serializer, the fifo_4 read port and the SSP pins.
// The master side is the serializer; the slave side is the fifo/pin environment.
interface ssp_tx_serializer_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty_i;
  logic [DATA_W-1:0] fifo_d_i;
  logic              fifo_rd_o;
  logic              sspclkout_o;
  logic              sspfssout_o;
  logic              ssptxd_o;
  logic              busy_o;
  logic              tx_done_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_d_i,
    output fifo_rd_o,
    output sspclkout_o,
    output sspfssout_o,
    output ssptxd_o,
    output busy_o,
    output tx_done_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_d_i,
    input  fifo_rd_o,
    input  sspclkout_o,
    input  sspfssout_o,
    input  ssptxd_o,
    input  busy_o,
    input  tx_done_o
  );
endinterface

// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: pops fifo_4 words and sends TI-format frames (fss pulse, then DATA_W bits).
// Optional build macro SSP_TX_LSB_FIRST_EN selects LSB-first transmission; default is MSB first.
module ssp_tx_serializer #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ssp_tx_serializer_if.master    bus
);

  localparam int T     = 2 * CLK_DIV;
  localparam int DIV_W = (T > 1) ? $clog2(T) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(T - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shreg_r;
  logic              fifo_rd_r;
  logic              sclk_r;
  logic              fss_r;
  logic              txd_r;
  logic              busy_r;
  logic              done_r;
  logic              tx_bit_s;

`ifdef SSP_TX_LSB_FIRST_EN
  assign tx_bit_s = shreg_r[0];

  function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] value);
    return {1'b0, value[DATA_W-1:1]};
  endfunction
`else
  assign tx_bit_s = shreg_r[DATA_W-1];

  function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] value);
    return {value[DATA_W-2:0], 1'b0};
  endfunction
`endif

  // Frame FSM, divider/bit counters, shift register and registered pin outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      shreg_r   <= '0;
      fifo_rd_r <= 1'b0;
      sclk_r    <= 1'b0;
      fss_r     <= 1'b0;
      txd_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      // Pins show the previous cycle's state, so fss starts the cycle after the pop strobe.
      busy_r    <= (state_r != IDLE);
      fss_r     <= (state_r == FRAME);
      sclk_r    <= (state_r != IDLE) && (div_cnt_r < DIV_HALF);
      txd_r     <= (state_r == SHIFT) ? tx_bit_s : 1'b0;
      fifo_rd_r <= 1'b0;
      done_r    <= 1'b0;

      case (state_r)
        IDLE: begin
          div_cnt_r <= '0;
          bit_cnt_r <= '0;
          if (!bus.fifo_empty_i) begin
            fifo_rd_r <= 1'b1;
            shreg_r   <= bus.fifo_d_i;
            state_r   <= FRAME;
          end else begin
            state_r   <= IDLE;
          end
        end

        FRAME: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            bit_cnt_r <= '0;
            state_r   <= SHIFT;
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end

        SHIFT: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= '0;
            shreg_r   <= shift_next(shreg_r);
            if (bit_cnt_r == BIT_LAST) begin
              done_r    <= 1'b1;
              bit_cnt_r <= '0;
              // Back-to-back frames: the next word is popped on the last-bit edge.
              if (!bus.fifo_empty_i) begin
                fifo_rd_r <= 1'b1;
                shreg_r   <= bus.fifo_d_i;
                state_r   <= FRAME;
              end else begin
                state_r   <= IDLE;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end
        end

        default: begin
          state_r   <= IDLE;
          div_cnt_r <= '0;
          bit_cnt_r <= '0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_o   = fifo_rd_r;
  assign bus.sspclkout_o = sclk_r;
  assign bus.sspfssout_o = fss_r;
  assign bus.ssptxd_o    = txd_r;
  assign bus.busy_o      = busy_r;
  assign bus.tx_done_o   = done_r;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Self-checking bench for ssp_tx_serializer: fifo_4 model, random pushes and a frame-offset reference model.
module tb_ssp_tx_serializer;

  localparam int DATA_W    = 8;
  localparam int CLK_DIV   = 2;
  localparam int T         = 2 * CLK_DIV;
  localparam int FRAME_LEN = (DATA_W + 1) * T;
  localparam int LAST      = FRAME_LEN - 1;
  localparam int FIFO_D    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ssp_tx_serializer_if #(.DATA_W(DATA_W)) ifc ();

  ssp_tx_serializer #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] push_q[$];

  // Reference model: k is the cycle offset inside the current frame on the pins (-1 = idle).
  int                k      = -1;
  bit                exp_rd = 1'b0;
  logic [DATA_W-1:0] cur    = '0;
  logic [DATA_W-1:0] pend   = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    int idx;
    if (k < T) return 1'b0;
    idx = k / T - 1;
`ifdef SSP_TX_LSB_FIRST_EN
    return cur[idx];
`else
    return cur[DATA_W-1-idx];
`endif
  endfunction

  task automatic drive_fifo();
    ifc.fifo_empty_i = (fifo_q.size() == 0);
    ifc.fifo_d_i     = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  // One clock: check pins, update fifo, apply reset for the next edge, advance the model.
  task automatic step(input bit rst_next);
    bit nrd;
    @(negedge clk);
    check_eq("fifo_rd", 32'(ifc.fifo_rd_o),   32'(exp_rd));
    check_eq("busy",    32'(ifc.busy_o),      32'(k >= 0));
    check_eq("fss",     32'(ifc.sspfssout_o), 32'(k >= 0 && k < T));
    check_eq("sclk",    32'(ifc.sspclkout_o), 32'(k >= 0 && (k % T) < CLK_DIV));
    check_eq("txd",     32'(ifc.ssptxd_o),    32'(exp_txd()));
    check_eq("tx_done", 32'(ifc.tx_done_o),   32'(k == LAST));

    if (ifc.fifo_rd_o && fifo_q.size() > 0) void'(fifo_q.pop_front());
    while (push_q.size() > 0 && fifo_q.size() < FIFO_D) fifo_q.push_back(push_q.pop_front());
    rst = rst_next;

    if (rst_next) begin
      k      = -1;
      exp_rd = 1'b0;
    end else begin
      nrd = (fifo_q.size() > 0) && !exp_rd && (k == -1 || k == LAST - 1 || k == LAST);
      if (nrd) pend = fifo_q[0];
      if (exp_rd) begin
        k   = 0;
        cur = pend;
      end else if (k >= 0 && k < LAST) begin
        k++;
      end else begin
        k = -1;
      end
      exp_rd = nrd;
    end
    drive_fifo();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // Asynchronous reset mid-cycle: pins must clear before the next clock edge.
  task automatic async_reset(input int hold);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_rd",   32'(ifc.fifo_rd_o),   32'd0);
    check_eq("arst_busy", 32'(ifc.busy_o),      32'd0);
    check_eq("arst_fss",  32'(ifc.sspfssout_o), 32'd0);
    check_eq("arst_sclk", 32'(ifc.sspclkout_o), 32'd0);
    check_eq("arst_txd",  32'(ifc.ssptxd_o),    32'd0);
    check_eq("arst_done", 32'(ifc.tx_done_o),   32'd0);
    k      = -1;
    exp_rd = 1'b0;
    for (int i = 0; i < hold; i++) step(1'b1);
    step(1'b0);
  endtask

  initial begin
    ifc.fifo_empty_i = 1'b1;
    ifc.fifo_d_i     = '0;
    rst = 1'b1;

    // Reset held 50 ns with the fifo empty.
    for (int i = 0; i < 5; i++) step(1'b1);
    step(1'b0);
    run(10);

    // Single frame.
    push_q.push_back(8'hA5);
    run(45);

    // Full fifo: four contiguous frames.
    push_q.push_back(8'h11);
    push_q.push_back(8'h22);
    push_q.push_back(8'h33);
    push_q.push_back(8'h44);
    run(160);

    // Word arriving mid-frame waits for frame end.
    push_q.push_back(8'h11);
    run(15);
    push_q.push_back(8'h55);
    run(85);

    // Reset during bit 3, then a clean frame.
    push_q.push_back(8'h3C);
    run(20);
    async_reset(3);
    run(10);
    push_q.push_back(8'h0F);
    run(45);

    push_q.push_back(8'h01);
    run(45);

    // Random traffic with occasional mid-frame resets.
    for (int i = 0; i < 3000; i++) begin
      if (push_q.size() == 0 && $urandom_range(0, 5) == 0)
        push_q.push_back(DATA_W'($urandom_range(0, 255)));
      if ($urandom_range(0, 799) == 0) async_reset($urandom_range(1, 4));
      else step(1'b0);
    end

    run(FRAME_LEN * (FIFO_D + 2));
    check_eq("fifo_drained", 32'(fifo_q.size() + push_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
